// File: rtl/ni_packet_injector.sv
// Frames FIFO payload into header/size/payload flits toward a router local port.
// Define NI_PACKET_INJECTOR_STORE_FWD_EN to withhold the header until the payload is buffered.
module ni_packet_injector #(
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [FLIT_WIDTH-1:0]       wr_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  input  logic                        pkt_start,
  input  logic [15:0]                 pkt_target,
  input  logic [15:0]                 pkt_size,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        clock_tx,
  output logic                        tx,
  output logic [FLIT_WIDTH-1:0]       data_o,
  input  logic                        credit_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_HEADER, S_SIZE, S_PAYLOAD
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD
  } state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_target;
  logic [15:0]           r_size;
  logic [15:0]           r_remain;
  logic                  r_done;
  logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_load;
  logic                  w_tx;
  logic [FLIT_WIDTH-1:0] w_data;

`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
  localparam logic [15:0] DEPTH16 = 16'(FIFO_DEPTH);
  logic [15:0] w_need;
  assign w_need = (r_size > DEPTH16) ? DEPTH16 : r_size;
`endif

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  // a push is dropped whenever the FIFO is full, even alongside a pop
  assign w_push = wr_en && !w_full;

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b0;
    w_data = '0;
    w_pop  = 1'b0;
    w_last = 1'b0;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pkt_start) begin
          w_load = 1'b1;
`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
          w_next = S_WAIT;
`else
          w_next = S_HEADER;
`endif
        end
      end
`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
      S_WAIT: begin
        if (16'(r_count) >= w_need) w_next = S_HEADER;
      end
`endif
      S_HEADER: begin
        w_tx   = 1'b1;
        w_data = FLIT_WIDTH'(r_target);
        if (credit_i) w_next = S_SIZE;
      end
      S_SIZE: begin
        w_tx   = 1'b1;
        w_data = FLIT_WIDTH'(r_size);
        if (credit_i) begin
          if (r_size == 16'd0) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        w_tx   = (r_count != '0);
        w_data = r_mem[r_rptr];
        if (w_tx && credit_i) begin
          w_pop = 1'b1;
          if (r_remain == 16'd1) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_size   <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (w_load) begin
        r_target <= pkt_target;
        r_size   <= pkt_size;
        r_remain <= pkt_size;
      end else if (w_pop) begin
        r_remain <= r_remain - 16'd1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
  assign pkt_done   = r_done;
  assign clock_tx   = clock;
  assign tx         = w_tx;
  assign data_o     = w_data;

endmodule

// File: tb/tb_ni_packet_injector.sv
// Directed testbench for ni_packet_injector.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ni_packet_injector;

  localparam int FW = 32;
  localparam int FD = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [FW-1:0] wr_data = '0;
  logic          pkt_start = 1'b0;
  logic [15:0]   pkt_target = '0;
  logic [15:0]   pkt_size = '0;
  logic          credit_i = 1'b0;
  logic          fifo_full;
  logic [4:0]    fifo_count;
  logic          busy;
  logic          pkt_done;
  logic          clock_tx;
  logic          tx;
  logic [FW-1:0] data_o;

  int tests = 0;
  int fails = 0;

  logic [FW-1:0] got[$];
  logic [FW-1:0] exp_q[$];
  int holds_bad;
  int first_c;
  int last_c;
  int done_c;
  bit done_seen;

  always #5 clock = ~clock;

  ni_packet_injector #(.FLIT_WIDTH(FW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .pkt_start(pkt_start), .pkt_target(pkt_target),
    .pkt_size(pkt_size), .busy(busy), .pkt_done(pkt_done),
    .clock_tx(clock_tx), .tx(tx), .data_o(data_o),
    .credit_i(credit_i)
  );

`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
  localparam int HDR_C = 2;
`else
  localparam int HDR_C = 1;
`endif

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    wr_en = 1'b0;
    pkt_start = 1'b0;
    credit_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic push_n(input logic [FW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      wr_en = 1'b1;
      wr_data = base + FW'(i);
    end
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // collects transferred flits into got; stops on pkt_done or a cycle bound
  task automatic run_pkt(input logic [15:0] tgt, input logic [15:0] sz,
                         input bit toggle);
    logic          p_tx;
    logic          p_cr;
    logic [FW-1:0] p_d;
    got.delete();
    holds_bad = 0;
    first_c = -1;
    last_c = -1;
    done_c = -1;
    done_seen = 0;
    p_tx = 1'b0;
    p_cr = 1'b0;
    p_d = '0;
    pkt_target = tgt;
    pkt_size = sz;
    pkt_start = 1'b1;
    credit_i = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      pkt_start = 1'b0;
      if (pkt_done) begin
        done_seen = 1;
        done_c = c;
        break;
      end
      if (p_tx && !p_cr && (!tx || data_o != p_d)) holds_bad++;
      credit_i = toggle ? ~credit_i : 1'b1;
      if (tx && credit_i) begin
        got.push_back(data_o);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      p_tx = tx;
      p_cr = credit_i;
      p_d = data_o;
    end
    credit_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b0 || data_o !== '0 || busy !== 1'b0 || pkt_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got tx=%b data=%h busy=%b done=%b exp 0 0 0 0",
               tx, data_o, busy, pkt_done);
    end
    tests++;
    if (fifo_count !== 5'd0 || fifo_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_fifo got count=%0d full=%b exp 0 0", fifo_count, fifo_full);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    push_n(32'hA000_0000, 4);
    tests++;
    if (fifo_count !== 5'd4) begin
      fails++;
      $display("FAIL basic_count got %0d exp 4", fifo_count);
    end
    run_pkt(16'h0011, 16'd4, 1'b0);
    exp_q = '{32'h0000_0011, 32'h0000_0004, 32'hA000_0000, 32'hA000_0001,
              32'hA000_0002, 32'hA000_0003};
    tests++;
    if (got.size() != 6) begin
      fails++;
      $display("FAIL basic_nflits got %0d exp 6", got.size());
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_flit%0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 'x, exp_q[i]);
      end
    end
    tests++;
    if (first_c != HDR_C || last_c - first_c != 5 || done_c != last_c + 1) begin
      fails++;
      $display("FAIL basic_timing got first=%0d last=%0d done=%0d exp %0d %0d %0d",
               first_c, last_c, done_c, HDR_C, HDR_C + 5, HDR_C + 6);
    end
    tests++;
    if (busy !== 1'b0 || fifo_count !== 5'd0) begin
      fails++;
      $display("FAIL basic_end got busy=%b count=%0d exp 0 0", busy, fifo_count);
    end
  endtask

  task automatic test_credit_toggle();
    do_reset();
    push_n(32'hB000_0000, 4);
    run_pkt(16'h0011, 16'd4, 1'b1);
    exp_q = '{32'h0000_0011, 32'h0000_0004, 32'hB000_0000, 32'hB000_0001,
              32'hB000_0002, 32'hB000_0003};
    tests++;
    if (got.size() != 6 || !done_seen) begin
      fails++;
      $display("FAIL toggle_nflits got %0d done=%0d exp 6 1", got.size(), done_seen);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL toggle_flit%0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 'x, exp_q[i]);
      end
    end
    tests++;
    if (holds_bad != 0) begin
      fails++;
      $display("FAIL toggle_hold got %0d unstable cycles exp 0", holds_bad);
    end
  endtask

  task automatic test_size0_back_to_back();
    do_reset();
    push_n(32'hC000_0000, 1);
    run_pkt(16'h0022, 16'd0, 1'b0);
    tests++;
    if (got.size() != 2 || got[0] !== 32'h22 || got[1] !== 32'h0) begin
      fails++;
      $display("FAIL size0_flits got n=%0d exp header 22 then 0", got.size());
    end
    tests++;
    if (done_c != last_c + 1 || fifo_count !== 5'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL size0_end got done=%0d count=%0d busy=%b exp %0d 1 0",
               done_c, fifo_count, busy, last_c + 1);
    end
    run_pkt(16'h0055, 16'd1, 1'b0);
    tests++;
    if (got.size() != 3 || got[0] !== 32'h55 || got[1] !== 32'h1 ||
        got[2] !== 32'hC000_0000) begin
      fails++;
      $display("FAIL b2b_flits got n=%0d exp 55 1 c0000000", got.size());
    end
    tests++;
    if (first_c != HDR_C || !done_seen || fifo_count !== 5'd0) begin
      fails++;
      $display("FAIL b2b_timing got first=%0d done=%0d count=%0d exp %0d 1 0",
               first_c, done_seen, fifo_count, HDR_C);
    end
  endtask

  task automatic test_full();
    int p;
    do_reset();
    push_n(32'hD000_0000, FD);
    tests++;
    if (fifo_count !== 5'd16 || fifo_full !== 1'b1) begin
      fails++;
      $display("FAIL full_fill got count=%0d full=%b exp 16 1", fifo_count, fifo_full);
    end
    push_n(32'hDEAD_BEEF, 1);
    tests++;
    if (fifo_count !== 5'd16 || fifo_full !== 1'b1) begin
      fails++;
      $display("FAIL full_drop got count=%0d full=%b exp 16 1", fifo_count, fifo_full);
    end
    got.delete();
    done_seen = 0;
    p = 0;
    pkt_target = 16'h0033;
    pkt_size = 16'd18;
    pkt_start = 1'b1;
    credit_i = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      pkt_start = 1'b0;
      wr_en = 1'b0;
      if (pkt_done) begin
        done_seen = 1;
        break;
      end
      if (tx) begin
        if (got.size() >= 2) begin
          if (p == 0) begin
            tests++;
            if (fifo_count !== 5'd16) begin
              fails++;
              $display("FAIL full_pay0_count got %0d exp 16", fifo_count);
            end
          end
          if (p == 5) begin
            tests++;
            if (fifo_count !== 5'd13) begin
              fails++;
              $display("FAIL full_pushpop_count got %0d exp 13", fifo_count);
            end
          end
          if (p == 3 || p == 4) begin
            wr_en = 1'b1;
            wr_data = 32'hE000_0000 + 32'(p - 3);
          end
          p++;
        end
        got.push_back(data_o);
      end
    end
    exp_q = '{32'h33, 32'd18};
    for (int i = 0; i < FD; i++) exp_q.push_back(32'hD000_0000 + 32'(i));
    exp_q.push_back(32'hE000_0000);
    exp_q.push_back(32'hE000_0001);
    tests++;
    if (got.size() != 20 || !done_seen) begin
      fails++;
      $display("FAIL full_nflits got %0d done=%0d exp 20 1", got.size(), done_seen);
    end
    for (int i = 0; i < 20; i++) begin
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        tests++;
        fails++;
        $display("FAIL full_order at %0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 'x, exp_q[i]);
        break;
      end
    end
    tests++;
    if (fifo_count !== 5'd0) begin
      fails++;
      $display("FAIL full_end_count got %0d exp 0", fifo_count);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    push_n(32'hF000_0000, 1);
    got.delete();
    done_seen = 0;
    pkt_target = 16'h0044;
    pkt_size = 16'd3;
    pkt_start = 1'b1;
    credit_i = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      pkt_start = 1'b0;
      wr_en = 1'b0;
      if (c == 5 || c == 6) begin
        wr_en = 1'b1;
        wr_data = 32'hF000_0000 + 32'(c - 4);
      end
      if (pkt_done) begin
        done_seen = 1;
        break;
      end
`ifdef NI_PACKET_INJECTOR_STORE_FWD_EN
      if (c == 7) begin
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL bubble_withheld got tx=%b busy=%b exp 0 1", tx, busy);
        end
      end
      if (c == 8) begin
        tests++;
        if (tx !== 1'b1 || data_o !== 32'h44) begin
          fails++;
          $display("FAIL bubble_header got tx=%b data=%h exp 1 44", tx, data_o);
        end
      end
`else
      if (c == 1) begin
        tests++;
        if (tx !== 1'b1 || data_o !== 32'h44) begin
          fails++;
          $display("FAIL bubble_header got tx=%b data=%h exp 1 44", tx, data_o);
        end
      end
      if (c == 4) begin
        tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL bubble_gap got tx=%b busy=%b exp 0 1", tx, busy);
        end
      end
`endif
      if (tx) got.push_back(data_o);
    end
    tests++;
    if (got.size() != 5 || !done_seen || got[0] !== 32'h44 || got[1] !== 32'd3 ||
        got[2] !== 32'hF000_0000 || got[3] !== 32'hF000_0001 ||
        got[4] !== 32'hF000_0002) begin
      fails++;
      $display("FAIL bubble_flits got n=%0d done=%0d exp 5 flits 44 3 f0..f2",
               got.size(), done_seen);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_n(32'h1000_0000, 4);
    pkt_target = 16'h0066;
    pkt_size = 16'd4;
    pkt_start = 1'b1;
    credit_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      pkt_start = 1'b0;
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre got tx=%b busy=%b exp 1 1", tx, busy);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0 || data_o !== '0) begin
      fails++;
      $display("FAIL midrst_async got tx=%b busy=%b count=%0d data=%h exp 0 0 0 0",
               tx, busy, fifo_count, data_o);
    end
    @(negedge clock);
    reset = 1'b1;
    push_n(32'h2000_0000, 2);
    run_pkt(16'h0077, 16'd2, 1'b0);
    tests++;
    if (got.size() != 4 || !done_seen || got[0] !== 32'h77 || got[1] !== 32'd2 ||
        got[2] !== 32'h2000_0000 || got[3] !== 32'h2000_0001) begin
      fails++;
      $display("FAIL midrst_after got n=%0d done=%0d exp 4 flits 77 2 20000000 20000001",
               got.size(), done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_toggle();
    test_size0_back_to_back();
    test_full();
    test_bubble();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ni_packet_injector.md
# ni_packet_injector

Network-interface transmit stage that sits directly upstream of a router local input port. A producer fills a payload FIFO word by word, then issues a packet command. The block frames the packet as a header flit, a size flit, and then the payload flits. It drives them into the router with credit-based flow control on the router's rx / data_i / credit_o local-port signals.

## Interface
Parameters:
- FLIT_WIDTH, 32, flit width; must be ≥ 16.
- FIFO_DEPTH, 16, payload FIFO entries; power of two, ≥ 2.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push wr_data into the payload FIFO.
- wr_data  in  FLIT_WIDTH  payload word.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- pkt_start  in  1  single-cycle command strobe.
- pkt_target  in  16  router address; placed in header flit bits [15:0].
- pkt_size  in  16  payload flit count; 0 is legal.
- busy  out  1  packet in progress (state ≠ IDLE).
- pkt_done  out  1  one-cycle pulse after the last flit is accepted.
- clock_tx  out  1  equals clock; drives the router's clock_rx.
- tx  out  1  flit valid; drives the router's rx.
- data_o  out  FLIT_WIDTH  flit; drives the router's data_i.
- credit_i  in  1  router can accept a flit; driven by the router's credit_o.

## Operation
- Transfer rule: a flit moves on a rising edge where tx=1 and credit_i=1.
  - data_o is held stable while tx=1 and credit_i=0.
- FSM states: IDLE, WAIT (only when the macro is defined), HEADER, SIZE, PAYLOAD.
- IDLE → HEADER on pkt_start.
  - pkt_target and pkt_size are latched at this point.
  - The remaining-payload counter is loaded with pkt_size.
- pkt_start is ignored while busy=1.
- HEADER: tx=1, data_o = {zero-extend, target}. Moves to SIZE on transfer.
- SIZE: tx=1, data_o = {zero-extend, size}. On transfer:
  - size==0: go to IDLE and pulse pkt_done.
  - otherwise: go to PAYLOAD.
- PAYLOAD:
  - tx = (fifo_count≠0); data_o = FIFO head (show-ahead).
  - Each transfer pops the FIFO and decrements the remaining counter.
  - The transfer at remaining==1 goes to IDLE and pulses pkt_done.
- An empty FIFO during PAYLOAD gives tx=0 (a bubble). Flits resume when data arrives.
- FIFO rules:
  - Push while full is dropped; contents and count are unchanged.
  - Simultaneous push and pop: count is unchanged and both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Outside PAYLOAD, data_o = 0 whenever tx=0.

## Timing
- Reset values:
  - tx=0, data_o=0, busy=0, pkt_done=0.
  - fifo_count=0, fifo_full=0, FSM=IDLE.
- Reset asserted mid-packet aborts the packet and flushes the FIFO. tx drops immediately (asynchronous).
- tx and data_o come from registered state and FIFO storage only. There is no combinational path from credit_i to tx or data_o.
- pkt_start sampled at edge N gives busy=1 and a header on data_o during cycle N+1.
- With credit_i held at 1, flits leave back-to-back: one per cycle, with no idle cycles between header, size and payload.
- Latency is pkt_size+2 cycles from the first header cycle to the last transfer.
- pkt_done is high for the cycle after the last transfer; busy=0 in that same cycle.
- pkt_start may be asserted in the pkt_done cycle; the next header then appears in the following cycle.
- A word pushed at edge N is visible in fifo_count and eligible for transfer from cycle N+1.

## Configuration
- NI_PACKET_INJECTOR_STORE_FWD_EN defined:
  - pkt_start moves IDLE → WAIT.
  - WAIT holds tx=0 until fifo_count ≥ min(size, FIFO_DEPTH), then moves to HEADER.
  - For size==0, WAIT lasts exactly one cycle.
  - With size ≤ FIFO_DEPTH, a packet is emitted with no payload bubbles.
- Macro undefined:
  - No WAIT state; cut-through operation exactly as described above.

## Test plan
- Push A0..A3, then pkt_start with target=0x0011, size=4, credit_i=1.
  - Expected: data_o sequence 0x00000011, 0x00000004, A0..A3 on 6 consecutive cycles.
  - Expected: pkt_done in the 7th cycle, fifo_count=0.
- Same packet with credit_i toggling 1,0,1,0,…
  - Expected: each flit is held across the credit_i=0 cycles.
  - Expected: exactly 6 transfers in order, with no duplicates or drops.
- pkt_start with size=0.
  - Expected: header, then size flit 0x00000000, then pkt_done.
  - Expected: FIFO is untouched.
- Fill FIFO_DEPTH words, push one more, then push and pop in the same cycle during PAYLOAD.
  - Expected: the extra push is dropped; fifo_full=1 and count=16.
  - Expected: during the simultaneous push/pop, count stays constant and ordering is preserved.
- Start a size=3 packet with 1 word buffered; push the remaining 2 words 5 cycles later.
  - Macro undefined: tx=0 bubble during the gap.
  - Macro defined: header is withheld until count=3.
- Assert reset during PAYLOAD.
  - Expected: tx=0, busy=0 and fifo_count=0 immediately.
  - Expected: a new packet after reset is sent correctly.
